// File: rtl/wordcell_array_pkg.sv
// Shared types and constants for the wordcell_array storage block.
package wordcell_array_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/masked_word_reg.sv
// One storage row: DW data bits with per-bit write mask, plus an optional
// even-parity bit recomputed from the merged word on every write.
// Contents are not reset; the owner zeroes them with a clear sweep.
module masked_word_reg #(
   parameter int DW     = 8,
   parameter bit PAR_EN = 1'b0
) (
   input  logic          clk,
   input  logic          we,
   input  logic [DW-1:0] mask,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] data,
   output logic          par
);

   logic [DW-1:0] data_q;
   logic [DW-1:0] merged;

   assign merged = (data_q & ~mask) | (din & mask);
   assign data   = data_q;

   // Masked row update: unmasked bits keep their old value.
   always_ff @(posedge clk) begin
      if (we) data_q <= merged;
   end

   generate
      if (PAR_EN) begin : g_par
         logic par_q;
         // Parity tracks the merged word, so a zero sweep stores parity 0.
         always_ff @(posedge clk) begin
            if (we) par_q <= ^merged;
         end
         assign par = par_q;
      end else begin : g_nopar
         assign par = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/wordcell_array.sv
// DEPTH x WIDTH word array with req/ready handshake, per-bit write mask,
// registered read data (latency 1) and a hardware zeroing sweep after reset
// or on clear_req. Optional stored parity: define WORDCELL_ARRAY_PARITY_EN.
module wordcell_array
   import wordcell_array_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req,
   input  logic             op,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wmask,
   input  logic [WIDTH-1:0] in_bus,
   input  logic             clear_req,
   output logic             ready,
   output logic [WIDTH-1:0] out_bus,
   output logic             out_valid,
   output logic             addr_err,
   output logic             busy,
   output logic             parity_err
);

`ifdef WORDCELL_ARRAY_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   state_t           state;
   logic [AW-1:0]    clr_cnt;
   logic             clearing;
   logic             accept, acc_wr, acc_rd;
   logic             hit;
   logic             rd_par;
   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] row_mask, row_din;
   logic [WIDTH-1:0] row_data [DEPTH];
   logic [DEPTH-1:0] row_par;
   logic [DEPTH-1:0] row_we;

   assign clearing = (state == ST_CLEAR);
   assign busy     = clearing;
   // A clear request steals the cycle, so a coincident req is refused.
   assign ready    = (state == ST_IDLE) & ~clear_req;
   assign accept   = req & ready;
   assign acc_wr   = accept & (op == OP_WRITE);
   assign acc_rd   = accept & (op == OP_READ);

   // During the sweep every row sees a full mask with zero data.
   assign row_mask = clearing ? '1 : wmask;
   assign row_din  = clearing ? '0 : in_bus;

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_row
         assign row_we[i] = clearing ? (clr_cnt == AW'(i))
                                     : (acc_wr && (addr == AW'(i)));
         masked_word_reg #(.DW(WIDTH), .PAR_EN(PAR_EN)) u_row (
            .clk  (clk),
            .we   (row_we[i]),
            .mask (row_mask),
            .din  (row_din),
            .data (row_data[i]),
            .par  (row_par[i])
         );
      end
   endgenerate

   // Read mux; hit doubles as the range check so no address aliases a row.
   always_comb begin
      rd_data = '0;
      rd_par  = 1'b0;
      hit     = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr == AW'(i)) begin
            rd_data = row_data[i];
            rd_par  = row_par[i];
            hit     = 1'b1;
         end
      end
   end

   // Sweep FSM plus registered response strobes and read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_CLEAR;
         clr_cnt    <= '0;
         out_bus    <= '0;
         out_valid  <= 1'b0;
         addr_err   <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         out_valid  <= acc_rd;
         addr_err   <= accept & ~hit;
         parity_err <= PAR_EN && acc_rd && hit && ((^rd_data) != rd_par);
         if (acc_rd) out_bus <= rd_data;
         case (state)
            ST_CLEAR: begin
               if (clr_cnt == AW'(DEPTH - 1)) state   <= ST_IDLE;
               else                           clr_cnt <= clr_cnt + AW'(1);
            end
            ST_IDLE: begin
               if (clear_req) begin
                  state   <= ST_CLEAR;
                  clr_cnt <= '0;
               end
            end
            default: state <= ST_CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_wordcell_array.sv
// Randomized self-checking bench for wordcell_array. Instance A uses DEPTH=16,
// instance B uses DEPTH=12 so out-of-range addresses are reachable.
module tb_wordcell_array;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_a = 1'b0, req_b = 1'b0;
   logic       op = 1'b0, clear_req = 1'b0;
   logic [3:0] addr = '0;
   logic [7:0] wmask = '0, in_bus = '0;

   logic       ready_a, out_valid_a, addr_err_a, busy_a, perr_a;
   logic       ready_b, out_valid_b, addr_err_b, busy_b, perr_b;
   logic [7:0] out_bus_a, out_bus_b;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] mem_a [16];
   logic [7:0] mem_b [12];
   logic [7:0] last_a = '0, last_b = '0;

   always #5 clk = ~clk;

   wordcell_array #(.WIDTH(8), .DEPTH(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .req(req_a), .op(op), .addr(addr),
      .wmask(wmask), .in_bus(in_bus), .clear_req(clear_req),
      .ready(ready_a), .out_bus(out_bus_a), .out_valid(out_valid_a),
      .addr_err(addr_err_a), .busy(busy_a), .parity_err(perr_a)
   );

   wordcell_array #(.WIDTH(8), .DEPTH(12)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .op(op), .addr(addr),
      .wmask(wmask), .in_bus(in_bus), .clear_req(clear_req),
      .ready(ready_b), .out_bus(out_bus_b), .out_valid(out_valid_b),
      .addr_err(addr_err_b), .busy(busy_b), .parity_err(perr_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // The sweep zeroes every word of both arrays.
   task automatic model_zero();
      foreach (mem_a[i]) mem_a[i] = '0;
      foreach (mem_b[i]) mem_b[i] = '0;
   endtask

   // Called just before the first sweep edge: 16 busy cycles, then ready.
   task automatic sweep_chk(input string tag);
      for (int i = 0; i < 16; i++) begin
         chk({tag, "/busy"}, busy_a, 1);
         chk({tag, "/nrdy"}, ready_a, 0);
         step();
      end
      chk({tag, "/rdy"}, ready_a, 1);
      chk({tag, "/idle"}, busy_a, 0);
      chk({tag, "/idle_b"}, busy_b, 0);
   endtask

   // One accepted access on instance A (b=0) or B (b=1), checked against the model.
   task automatic access(input bit b, input bit wr, input int a, input logic [7:0] m,
                         input logic [7:0] d, input bit exp_perr, input string tag);
      int         depth;
      bit         inr;
      logic [7:0] exp_out;
      depth = b ? 12 : 16;
      inr   = (a < depth);
      op = wr; addr = a[3:0]; wmask = m; in_bus = d;
      req_a = !b; req_b = b;
      chk({tag, "/ready"}, b ? ready_b : ready_a, 1);
      step();
      req_a = 1'b0; req_b = 1'b0;
      if (wr) begin
         if (inr) begin
            if (b) mem_b[a] = (mem_b[a] & ~m) | (d & m);
            else   mem_a[a] = (mem_a[a] & ~m) | (d & m);
         end
      end else begin
         exp_out = inr ? (b ? mem_b[a] : mem_a[a]) : 8'h00;
         if (b) last_b = exp_out; else last_a = exp_out;
      end
      chk({tag, "/valid"}, b ? out_valid_b : out_valid_a, !wr);
      chk({tag, "/other_valid"}, b ? out_valid_a : out_valid_b, 0);
      chk({tag, "/addr_err"}, b ? addr_err_b : addr_err_a, !inr);
      chk({tag, "/out_bus"}, b ? out_bus_b : out_bus_a, b ? last_b : last_a);
      chk({tag, "/perr"}, b ? perr_b : perr_a, exp_perr && !wr);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst/busy", busy_a, 1);
      chk("rst/ready", ready_a, 0);
      chk("rst/out_bus", out_bus_a, 0);
      chk("rst/out_valid", out_valid_a, 0);
      chk("rst/addr_err", addr_err_a, 0);
      chk("rst/perr", perr_a, 0);
      rst_n = 1'b1;
      sweep_chk("sweep0");
      model_zero();
      for (int a = 0; a < 16; a++) access(0, 0, a, 8'h00, 8'h00, 0, "sweep_rd");

      // Masked write
      access(0, 1, 3, 8'hFF, 8'hFF, 0, "mw1");
      access(0, 1, 3, 8'h0F, 8'h00, 0, "mw2");
      access(0, 0, 3, 8'h00, 8'h00, 0, "mw_rd");
      chk("mw/const", out_bus_a, 8'hF0);

      // Back-to-back reads straight after a write
      access(0, 1, 5, 8'hFF, 8'hA5, 0, "b2b_wr");
      access(0, 0, 5, 8'h00, 8'h00, 0, "b2b_rd5");
      chk("b2b/a5", out_bus_a, 8'hA5);
      access(0, 0, 6, 8'h00, 8'h00, 0, "b2b_rd6");
      chk("b2b/00", out_bus_a, 8'h00);

      // Out of range on the DEPTH=12 instance
      access(0, 1, 15, 8'hFF, 8'h3C, 0, "oor_a15");
      access(0, 0, 15, 8'h00, 8'h00, 0, "oor_a15rd");
      chk("oor/a15", out_bus_a, 8'h3C);
      access(1, 1, 11, 8'hFF, 8'h3C, 0, "oor_b11");
      access(1, 1, 12, 8'hFF, 8'h77, 0, "oor_b12");
      access(1, 0, 11, 8'h00, 8'h00, 0, "oor_b11rd");
      chk("oor/b11", out_bus_b, 8'h3C);
      access(1, 0, 12, 8'h00, 8'h00, 0, "oor_b12rd");
      chk("oor/b12", out_bus_b, 8'h00);
      access(1, 0, 0, 8'h00, 8'h00, 0, "oor_b0rd");

      // Random traffic with occasional idle cycles checking hold behaviour
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            step();
            chk("idle/valid_a", out_valid_a, 0);
            chk("idle/valid_b", out_valid_b, 0);
            chk("idle/hold_a", out_bus_a, last_a);
            chk("idle/hold_b", out_bus_b, last_b);
            chk("idle/aerr", addr_err_a | addr_err_b, 0);
         end else begin
            access($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
                   8'($urandom), 8'($urandom), 0, "rnd");
         end
      end

      // Clear collides with a write: write refused, full sweep runs
      clear_req = 1'b1; op = 1'b1; addr = 4'd2; in_bus = 8'h11; wmask = 8'hFF; req_a = 1'b1;
      #1;
      chk("coll/ready", ready_a, 0);
      step();
      clear_req = 1'b0; req_a = 1'b0;
      sweep_chk("coll_sweep");
      model_zero();
      access(0, 0, 2, 8'h00, 8'h00, 0, "coll_rd2");
      chk("coll/a2", out_bus_a, 8'h00);

      // Async reset at sweep cycle 7 restarts a full sweep
      access(0, 1, 9, 8'hFF, 8'h5A, 0, "pre_clr");
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      repeat (7) step();
      chk("rst7/busy", busy_a, 1);
      rst_n = 1'b0;
      #1;
      chk("rst7/ready", ready_a, 0);
      step();
      rst_n = 1'b1;
      sweep_chk("rst7_sweep");
      model_zero();
      last_a = '0; last_b = '0;
      access(0, 0, 9, 8'h00, 8'h00, 0, "rst7_rd9");

      // Reset during a read pulse drops it
      access(0, 1, 4, 8'hFF, 8'hC3, 0, "rd_rst_wr");
      access(0, 0, 4, 8'h00, 8'h00, 0, "rd_rst_rd");
      rst_n = 1'b0;
      #1;
      chk("rd_rst/valid", out_valid_a, 0);
      chk("rd_rst/bus", out_bus_a, 0);
      step();
      rst_n = 1'b1;
      sweep_chk("rd_rst_sweep");
      model_zero();
      last_a = '0; last_b = '0;

      // Parity: corrupt a stored bit behind the array's back
      access(0, 1, 1, 8'hFF, 8'h07, 0, "par_wr");
`ifdef WORDCELL_ARRAY_PARITY_EN
      dut_a.g_row[1].u_row.data_q[0] = ~dut_a.g_row[1].u_row.data_q[0];
      mem_a[1] = mem_a[1] ^ 8'h01;
      access(0, 0, 1, 8'h00, 8'h00, 1, "par_rd");
      chk("par/err", perr_a, 1);
`else
      access(0, 0, 1, 8'h00, 8'h00, 0, "par_rd");
      chk("par/err", perr_a, 0);
`endif
      chk("par/valid", out_valid_a, 1);
      access(1, 0, 13, 8'h00, 8'h00, 0, "par_oor");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
